// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
//
// Purpose:
//   Drives a 4-digit multiplexed decimal display from a 16-bit binary value.
//   A new value is accepted through a load/ready handshake and is held
//   pending. At the next frame boundary it is converted to BCD and latched.
//   The latched value is then scanned out one digit at a time, with
//   leading-zero blanking and an overflow indication. Because the displayed
//   value changes only at a frame boundary, a frame never mixes digits from
//   two values.
//
// Parameters:
//   DWELL     clock cycles each digit stays selected (2..65535)
//   BLANK_LZ  1 = blank leading zero digits 3..1, 0 = show all digits
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   value_in     in   [15:0] binary value to display
//   load         in   request to accept value_in
//   ready        out  a load is accepted this cycle (no value pending)
//   digit_sel    out  [3:0] one-hot digit select, bit 0 = units
//   digit_bcd    out  [3:0] BCD code of the selected digit
//   digit_blank  out  selected digit must be unlit
//   overflow     out  displayed value is >= 10000
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
    parameter int unsigned DWELL    = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic        ready,
    output logic [3:0]  digit_sel,
    output logic [3:0]  digit_bcd,
    output logic        digit_blank,
    output logic        overflow
);

    localparam logic [15:0] CNT_LAST = 16'(DWELL - 1);
    localparam logic [15:0] MAX_DEC  = 16'd10000;

    // Double-dabble conversion. Five BCD digits of scratch cover the whole
    // 16-bit range; only the low four are returned, because callers pass
    // values below 10000 only.
    function automatic logic [15:0] convert_to_bcd(input logic [15:0] bin);
        logic [19:0] bcd;
        bcd = 20'd0;
        for (int i = 15; i >= 0; i--) begin
            for (int d = 0; d < 5; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end else begin
                    bcd[4*d +: 4] = bcd[4*d +: 4];
                end
            end
            bcd = {bcd[18:0], bin[i]};
        end
        return bcd[15:0];
    endfunction

    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_pend_val;
    logic        r_pend_valid;
    logic [15:0] r_disp_bcd;
    logic        r_disp_ovf;

    logic        w_wrap;
    logic        w_frame_end;
    logic [3:0]  w_nibble;
    logic [3:0]  w_lz;

    assign w_wrap      = (r_cnt == CNT_LAST);
    assign w_frame_end = w_wrap && (r_idx == 2'd3);

    // Dwell counter and digit index: each digit held for DWELL cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= 16'd0;
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_cnt <= 16'd0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 16'd1;
            r_idx <= r_idx;
        end
    end

    // Pending value handshake and frame-boundary update of the display.
    // A load that coincides with a boundary where nothing is pending only
    // becomes pending; it is shown at the following boundary.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pend_val   <= 16'd0;
            r_pend_valid <= 1'b0;
            r_disp_bcd   <= 16'd0;
            r_disp_ovf   <= 1'b0;
        end else if (w_frame_end && r_pend_valid) begin
            r_pend_valid <= 1'b0;
            r_pend_val   <= r_pend_val;
            if (r_pend_val < MAX_DEC) begin
                r_disp_bcd <= convert_to_bcd(r_pend_val);
                r_disp_ovf <= 1'b0;
            end else begin
                // Keep the last valid digits; overflow forces all digits to F.
                r_disp_bcd <= r_disp_bcd;
                r_disp_ovf <= 1'b1;
            end
        end else if (load && !r_pend_valid) begin
            r_pend_val   <= value_in;
            r_pend_valid <= 1'b1;
            r_disp_bcd   <= r_disp_bcd;
            r_disp_ovf   <= r_disp_ovf;
        end else begin
            r_pend_val   <= r_pend_val;
            r_pend_valid <= r_pend_valid;
            r_disp_bcd   <= r_disp_bcd;
            r_disp_ovf   <= r_disp_ovf;
        end
    end

    // Leading-zero chain: w_lz[i] is set when digits 3 down to i are all zero.
    // Digit 0 never takes part, so a zero value still shows one "0".
    always_comb begin
        w_lz    = 4'b0000;
        w_lz[3] = (r_disp_bcd[15:12] == 4'd0);
        w_lz[2] = w_lz[3] && (r_disp_bcd[11:8] == 4'd0);
        w_lz[1] = w_lz[2] && (r_disp_bcd[7:4]  == 4'd0);
        w_lz[0] = 1'b0;
    end

    // Digit outputs, decoded purely from registered state.
    always_comb begin
        ready       = !r_pend_valid;
        digit_sel   = 4'b0001 << r_idx;
        overflow    = r_disp_ovf;
        w_nibble    = r_disp_bcd[{r_idx, 2'b00} +: 4];
        digit_bcd   = w_nibble;
        digit_blank = 1'b0;
        if (r_disp_ovf) begin
            digit_bcd   = 4'hF;
            digit_blank = 1'b0;
        end else begin
            digit_bcd   = w_nibble;
            digit_blank = BLANK_LZ && w_lz[r_idx];
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scanner
//
// Drives two scanners (BLANK_LZ=1 and BLANK_LZ=0, DWELL=4) from the same
// inputs. Their outputs are compared every cycle against a decimal model.
// The model tracks a cycle count since reset, the pending value and the
// displayed integer. It derives the expected digit, blanking and select from
// plain arithmetic.
// -----------------------------------------------------------------------------
module tb_bcd_display_scanner;

    localparam int DW    = 4;
    localparam int FRAME = 4 * DW;

    logic        clk;
    logic        reset_n;
    logic [15:0] value_in;
    logic        load;

    logic        ready_a, ready_b;
    logic [3:0]  sel_a, sel_b, bcd_a, bcd_b;
    logic        blank_a, blank_b, ovf_a, ovf_b;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state.
    int m_t;
    int m_pend;
    bit m_pv;
    int m_disp;
    bit m_ovf;

    bcd_display_scanner #(.DWELL(DW), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .load(load),
        .ready(ready_a), .digit_sel(sel_a), .digit_bcd(bcd_a),
        .digit_blank(blank_a), .overflow(ovf_a)
    );

    bcd_display_scanner #(.DWELL(DW), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .load(load),
        .ready(ready_b), .digit_sel(sel_b), .digit_bcd(bcd_b),
        .digit_blank(blank_b), .overflow(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    function automatic int pow10(input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return p;
    endfunction

    // Model update for the edge about to happen, using the current inputs.
    task automatic model_edge();
        if (!reset_n) begin
            m_t = 0; m_pend = 0; m_pv = 1'b0; m_disp = 0; m_ovf = 1'b0;
        end else begin
            if ((m_t % FRAME) == FRAME - 1 && m_pv) begin
                if (m_pend < 10000) begin
                    m_disp = m_pend;
                    m_ovf  = 1'b0;
                end else begin
                    m_ovf  = 1'b1;
                end
                m_pv = 1'b0;
            end else if (load && !m_pv) begin
                m_pend = int'(value_in);
                m_pv   = 1'b1;
            end
            m_t++;
        end
    endtask

    task automatic check_all();
        int i;
        int dig;
        bit lz;
        i   = (m_t / DW) % 4;
        dig = (m_disp / pow10(i)) % 10;
        lz  = (i >= 1) && (m_disp < pow10(i));
        chk("ready_a", 32'(ready_a), 32'(!m_pv));
        chk("ready_b", 32'(ready_b), 32'(!m_pv));
        chk("sel_a",   32'(sel_a),   32'(1 << i));
        chk("sel_b",   32'(sel_b),   32'(1 << i));
        chk("ovf_a",   32'(ovf_a),   32'(m_ovf));
        chk("ovf_b",   32'(ovf_b),   32'(m_ovf));
        chk("bcd_a",   32'(bcd_a),   m_ovf ? 32'hF : 32'(dig));
        chk("bcd_b",   32'(bcd_b),   m_ovf ? 32'hF : 32'(dig));
        chk("blank_a", 32'(blank_a), m_ovf ? 32'd0 : 32'(lz));
        chk("blank_b", 32'(blank_b), 32'd0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic load_val(input logic [15:0] v);
        load     = 1'b1;
        value_in = v;
        tick();
        load     = 1'b0;
        value_in = 16'($urandom);
    endtask

    // Advance until the next edge is a frame boundary with nothing pending.
    task automatic to_boundary();
        int guard;
        guard = 0;
        while (((m_t % FRAME) != FRAME - 1 || m_pv) && guard < 4 * FRAME) begin
            tick();
            guard++;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        value_in = 16'd0;
        m_t = 0; m_pend = 0; m_pv = 1'b0; m_disp = 0; m_ovf = 1'b0;
        #2;

        // Reset state and one idle frame.
        run(2);
        reset_n = 1'b1;
        run(FRAME);

        // 1234 loaded mid-frame.
        run(5);
        load_val(16'd1234);
        run(2 * FRAME);

        // Leading-zero blanking on 42 (both blanking modes).
        load_val(16'd42);
        run(2 * FRAME);

        // 9999, then 10000 (overflow), then 7.
        load_val(16'd9999);
        run(2 * FRAME);
        load_val(16'd10000);
        run(2 * FRAME);
        load_val(16'd7);
        run(2 * FRAME);

        // Back-to-back loads: second one is ignored.
        load_val(16'd5);
        load_val(16'd7);
        run(2 * FRAME);

        // Load exactly on the boundary edge with nothing pending.
        to_boundary();
        load_val(16'd314);
        run(2 * FRAME);

        // Reset with a value pending, before the boundary.
        to_boundary();
        run(2);
        load_val(16'd8888);
        run(3);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        run(2 * FRAME);

        // Random loads, including overflowing values.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                load     = 1'b1;
                value_in = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                       : 16'($urandom_range(0, 9999));
            end else begin
                load     = 1'b0;
                value_in = 16'($urandom);
            end
            if ($urandom_range(0, 150) == 0) reset_n = 1'b0;
            else                             reset_n = 1'b1;
            tick();
        end
        load    = 1'b0;
        reset_n = 1'b1;
        run(FRAME);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Sequencing controller that drives a 4-digit multiplexed decimal display from a 16-bit binary value.
- Accepts a new value through a load/ready handshake and holds it pending.
- At the next frame boundary it converts the pending value with the combinational convert_to_bcd, latches the result, and scans one digit at a time.
- Applies leading-zero blanking and overflow indication; sits between CPU output registers and the board display.

Parameters:
- DWELL, 50000, clock cycles each digit stays selected; legal range 2..65535.
- BLANK_LZ, 1, 1 = blank leading zero digits 3..1; 0 = show all digits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- value_in  input  16  binary value to display.
- load  input  1  request to accept value_in.
- ready  output  1  high when a load will be accepted this cycle.
- digit_sel  output  4  one-hot, active-high; bit i selects digit i (0 = units).
- digit_bcd  output  4  BCD code for the selected digit.
- digit_blank  output  1  high = selected digit must be unlit.
- overflow  output  1  high while the displayed value is >= 10000.

Behaviour:
- One clock, clk; reset_n is synchronous and active-low, sampled on the rising edge of clk.
- State:
  - pend_val[15:0], pend_valid
  - disp_bcd[15:0], disp_ovf
  - dwell counter cnt (0..DWELL-1)
  - digit index idx (0..3)
- Reset (reset_n=0 at an edge): cnt=0, idx=0, pend_valid=0, pend_val=0, disp_bcd=0, disp_ovf=0.
  - Resulting outputs: ready=1, digit_sel=4'b0001, digit_bcd=0, digit_blank=0, overflow=0.
  - Reset mid-frame or with a load pending discards the pending value.
- ready = !pend_valid. It is combinational from state only; there is no path from load or value_in to any output.
- Accept: load && ready at an edge sets pend_val=value_in and pend_valid=1, so ready=0 from the next cycle. load while ready=0 is ignored and the pending value is unchanged.
- Dwell counter:
  - cnt increments every cycle and wraps at DWELL-1 to 0.
  - On the wrap, idx advances: 0->1->2->3->0.
  - Each digit is selected for exactly DWELL cycles; a frame is 4*DWELL cycles.
- Frame boundary is the edge where cnt==DWELL-1 and idx==3. If pend_valid at that edge:
  - If pend_val < 10000: disp_bcd = convert_to_bcd(pend_val) and disp_ovf=0.
  - Otherwise: disp_ovf=1 and disp_bcd is unchanged.
  - pend_valid clears, so ready=1 and the new value is displayed from the first cycle of the new idx=0 dwell.
- Simultaneous load and frame boundary with pend_valid=0: the value is captured as pending and displayed at the following boundary, not this one.
- Outputs for selected digit i:
  - digit_sel = 1<<idx; overflow = disp_ovf.
  - When disp_ovf=1: digit_bcd=4'hF and digit_blank=0 on every digit.
  - Otherwise digit_bcd = disp_bcd[4i+3:4i].
  - digit_blank=1 iff BLANK_LZ=1, i>=1, and every nibble from digit 3 down to digit i is zero. Digit 0 is never blanked, so 0 displays as a single "0".
- disp_bcd never changes except at a frame boundary, so the display never tears mid-frame.

Test Plan (DWELL=4 unless stated):
- Reset, then run 16 cycles:
  - ready=1 and overflow=0 throughout.
  - digit_sel steps 0001,0010,0100,1000, 4 cycles each.
  - digit_bcd=0 throughout; digit_blank=0,1,1,1 per digit.
- Load 1234 mid-frame:
  - ready=0 next cycle and the display is unchanged until the wrap to idx=0.
  - Then digits 0..3 show 4,3,2,1, none blank, and ready=1 in the same cycle.
- Load 42:
  - BLANK_LZ=1: digits show 2,4 (unblanked), then digits 2 and 3 blank.
  - BLANK_LZ=0: digits show 2,4,0,0, all unblanked.
- Load 9999, then 10000 after the next boundary:
  - First frame shows 9,9,9,9 with overflow=0.
  - Next frame: overflow=1 and every digit shows F, unblanked.
  - Then load 7: overflow=0 and the display shows 7 with digits 1..3 blank.
- Back-to-back loads:
  - Load 5, then load 7 on the next cycle (ready=0, ignored): 5 is displayed.
  - Load asserted exactly on the boundary edge with nothing pending: the value appears one frame later (4*DWELL cycles after that boundary).
- Reset mid-operation:
  - Load 8888, assert reset_n=0 before the boundary: outputs return to the reset values, 8888 is never displayed, and ready=1.
